// File: rtl/cdc_handshake_sender.sv
// 4-phase req/ack sender: latches a word on accept and holds it on data_out until the remote side acks.
// Accept-to-done is 2*SYNC_STAGES+2 cycles minimum; din_ready is low while busy or while a stale ack is still high.
module cdc_handshake_sender #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clkA,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             done,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TMO_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          cnt_inc;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   tmo_q, tmo_d;
  logic                   ack_s;
  logic                   accept;
  logic                   tmo_hit;

  // ack_in is only ever seen through this shift chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ack_in};
  end

  assign ack_s     = sync_q[SYNC_STAGES-1];
  assign din_ready = (state_q == IDLE) && !ack_s;
  assign accept    = din_valid && din_ready;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign tmo_hit   = TMO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          data_d  = din;
          req_d   = 1'b1;
          tmo_d   = 1'b0;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        cnt_d = cnt_inc;
        if (ack_s) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = REQ_LO;
        end else if (tmo_hit) begin
          // abandon the request; the trailing REQ_LO phase must not report completion
          req_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        cnt_d = cnt_inc;
        if (!ack_s) begin
          done_d  = !tmo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign data_out    = data_q;
  assign req_out     = req_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// Directed bench: instance a has TIMEOUT=16, instance b has the timeout disabled.
module tb_cdc_handshake_sender;

  logic        clk;
  logic        rst_n;

  logic [31:0] a_din, a_data_out;
  logic        a_din_valid, a_din_ready, a_req_out, a_ack_in, a_done, a_busy, a_err, a_err_clr;
  logic [31:0] b_din, b_data_out;
  logic        b_din_valid, b_din_ready, b_req_out, b_ack_in, b_done, b_busy, b_err, b_err_clr;

  int vectors     = 0;
  int miscompares = 0;

  bit          a_mirror;
  int          a_done_cnt;
  bit          b_run, b_auto;
  int          b_wait, b_ak, b_dk, b_done_cnt, b_unstable;
  logic        b_prev_req;
  logic [31:0] b_prev_data;
  int          n, lat, drop;

  logic [31:0] words [10] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h1234_5678, 32'h8765_4321,
                              32'hDEAD_0001, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hCAFE_BABE,
                              32'h5A5A_A5A5, 32'h7FFF_0000};

  cdc_handshake_sender #(.WIDTH(32), .SYNC_STAGES(2), .TIMEOUT(16)) u_a (
    .clkA(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
    .data_out(a_data_out), .req_out(a_req_out), .ack_in(a_ack_in), .done(a_done),
    .busy(a_busy), .timeout_err(a_err), .err_clr(a_err_clr)
  );

  cdc_handshake_sender #(.WIDTH(32), .SYNC_STAGES(2), .TIMEOUT(0)) u_b (
    .clkA(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .data_out(b_data_out), .req_out(b_req_out), .ack_in(b_ack_in), .done(b_done),
    .busy(b_busy), .timeout_err(b_err), .err_clr(b_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, then update the remote-side models.
  task automatic tick();
    bit bacc;
    bacc = b_run && b_din_valid && b_din_ready;
    @(posedge clk);
    #1;
    if (a_done) a_done_cnt++;
    if (b_done) begin
      b_done_cnt++;
      if (b_dk < 10) begin
        chk($sformatf("b_word%0d", b_dk), 64'(b_data_out), 64'(words[b_dk]));
        b_dk++;
      end
    end
    if (b_req_out && b_prev_req && (b_data_out !== b_prev_data)) b_unstable++;
    b_prev_req  = b_req_out;
    b_prev_data = b_data_out;
    if (bacc) begin
      b_ak++;
      if (b_ak < 10) b_din = words[b_ak];
      else b_din_valid = 1'b0;
    end
    if (a_mirror) a_ack_in = a_req_out;
    if (b_auto && (b_ack_in != b_req_out)) begin
      if (b_wait == 0) begin
        b_ack_in = b_req_out;
        b_wait   = int'($urandom_range(20, 0));
      end else begin
        b_wait--;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_din = '0; a_din_valid = 1'b0; a_ack_in = 1'b0; a_err_clr = 1'b0;
    b_din = '0; b_din_valid = 1'b0; b_ack_in = 1'b0; b_err_clr = 1'b0;
    a_mirror = 1'b0; a_done_cnt = 0;
    b_run = 1'b0; b_auto = 1'b0; b_wait = 0; b_ak = 0; b_dk = 0; b_done_cnt = 0; b_unstable = 0;
    b_prev_req = 1'b0; b_prev_data = '0;

    // reset state
    tick(); tick();
    chk("rst_req",   64'(a_req_out),   64'(0));
    chk("rst_data",  64'(a_data_out),  64'(0));
    chk("rst_done",  64'(a_done),      64'(0));
    chk("rst_busy",  64'(a_busy),      64'(0));
    chk("rst_err",   64'(a_err),       64'(0));
    chk("rst_b_req", 64'(b_req_out),   64'(0));
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(a_din_ready), 64'(1));

    // basic transfer, remote mirrors req_out
    a_mirror = 1'b1;
    a_din = 32'hA5A5_1234; a_din_valid = 1'b1;
    tick();
    a_din_valid = 1'b0; a_din = 32'hFFFF_FFFF;
    chk("hs_req",   64'(a_req_out),   64'(1));
    chk("hs_data",  64'(a_data_out),  64'hA5A5_1234);
    chk("hs_busy",  64'(a_busy),      64'(1));
    chk("hs_ready", 64'(a_din_ready), 64'(0));
    lat = 1;
    while (!a_done && lat < 40) begin
      if (a_req_out) chk("hs_data_hold", 64'(a_data_out), 64'hA5A5_1234);
      tick();
      lat++;
    end
    // accept cycle to done cycle: 7 cycles (done registered 6 edges after the accept edge)
    chk("hs_latency",  64'(lat),        64'(7));
    chk("hs_done_cnt", 64'(a_done_cnt), 64'(1));
    tick();
    chk("hs_done_pulse", 64'(a_done),     64'(0));
    chk("hs_idle",       64'(a_busy),     64'(0));
    chk("hs_data_after", 64'(a_data_out), 64'hA5A5_1234);
    a_mirror = 1'b0; a_ack_in = 1'b0;

    // REQ_HI timeout with remote never acking
    a_din = 32'h0BAD_F00D; a_din_valid = 1'b1;
    tick();
    a_din_valid = 1'b0;
    n = 0;
    while (a_req_out && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_req_fall", 64'(n),          64'(16));
    chk("tmo_err",      64'(a_err),      64'(1));
    chk("tmo_busy_lo",  64'(a_busy),     64'(1));
    chk("tmo_data",     64'(a_data_out), 64'h0BAD_F00D);
    tick();
    chk("tmo_idle",  64'(a_busy),      64'(0));
    chk("tmo_ready", 64'(a_din_ready), 64'(1));
    tick(); tick();
    chk("tmo_no_done",  64'(a_done_cnt), 64'(1));
    chk("tmo_err_held", 64'(a_err),      64'(1));

    // err_clr alone, then err_clr coinciding with a timeout
    a_err_clr = 1'b1; tick(); a_err_clr = 1'b0;
    chk("clr_err", 64'(a_err), 64'(0));
    a_din = 32'h5555_AAAA; a_din_valid = 1'b1;
    tick();
    a_din_valid = 1'b0;
    repeat (15) tick();
    chk("pre_fire_req", 64'(a_req_out), 64'(1));
    chk("pre_fire_err", 64'(a_err),     64'(0));
    a_err_clr = 1'b1; tick(); a_err_clr = 1'b0;
    chk("set_wins_err", 64'(a_err),     64'(1));
    chk("set_wins_req", 64'(a_req_out), 64'(0));
    a_err_clr = 1'b1; tick(); a_err_clr = 1'b0;
    chk("clr2_err",  64'(a_err),      64'(0));
    chk("clr2_idle", 64'(a_busy),     64'(0));
    chk("clr2_data", 64'(a_data_out), 64'h5555_AAAA);
    chk("clr2_done", 64'(a_done_cnt), 64'(1));

    // reset in the middle of REQ_HI, stale ack afterwards
    a_din = 32'h1111_2222; a_din_valid = 1'b1;
    tick();
    a_din_valid = 1'b0;
    tick(); tick();
    chk("r39_req", 64'(a_req_out), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_req",  64'(a_req_out),  64'(0));
    chk("async_busy", 64'(a_busy),     64'(0));
    chk("async_data", 64'(a_data_out), 64'(0));
    a_ack_in = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    a_din = 32'h3333_4444; a_din_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("stale_ready", 64'(a_din_ready), 64'(0));
      chk("stale_busy",  64'(a_busy),      64'(0));
    end
    a_ack_in = 1'b0;
    tick();
    chk("rel1_ready", 64'(a_din_ready), 64'(0));
    tick();
    chk("rel2_ready", 64'(a_din_ready), 64'(1));
    chk("rel2_busy",  64'(a_busy),      64'(0));
    tick();
    a_din_valid = 1'b0;
    chk("post_acc_busy", 64'(a_busy),     64'(1));
    chk("post_acc_data", 64'(a_data_out), 64'h3333_4444);
    a_mirror = 1'b1;
    n = 0;
    while (!a_done && n < 40) begin
      tick();
      n++;
    end
    chk("r39_done", 64'(a_done), 64'(1));
    a_mirror = 1'b0;

    // ten back-to-back words, random remote delay, timeout disabled
    b_run = 1'b1; b_auto = 1'b1;
    b_wait = int'($urandom_range(20, 0));
    b_din = words[0]; b_din_valid = 1'b1;
    n = 0;
    while (b_dk < 10 && n < 2000) begin
      tick();
      n++;
    end
    repeat (60) tick();
    chk("b_done_cnt", 64'(b_done_cnt), 64'(10));
    chk("b_accepts",  64'(b_ak),       64'(10));
    chk("b_unstable", 64'(b_unstable), 64'(0));
    chk("b_idle",     64'(b_busy),     64'(0));
    b_run = 1'b0; b_auto = 1'b0;

    // timeout disabled: request stays up indefinitely
    b_ack_in = 1'b0;
    b_din = 32'hDEAD_BEEF; b_din_valid = 1'b1;
    tick();
    b_din_valid = 1'b0;
    drop = 0;
    repeat (5000) begin
      tick();
      if (!b_req_out || b_err) drop++;
    end
    chk("t0_drop", 64'(drop),       64'(0));
    chk("t0_req",  64'(b_req_out),  64'(1));
    chk("t0_err",  64'(b_err),      64'(0));
    chk("t0_busy", 64'(b_busy),     64'(1));
    chk("t0_data", 64'(b_data_out), 64'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
